regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Multi-cycle initiator for the 4-entry × 4-bit register file. It accepts one instruction at a time over a valid/ready handshake and sequences READ → EXEC → WB. It drives the register file's read selects, write select, write enable and write data, and consumes its two combinational read outputs. It is the control/datapath front end that sits between the instruction source and the register file.

## Interface
Parameters:
- DATA_W, 4, register and ALU data width; must match the register file.
- ADDR_W, 2, register index width; must match the register file.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction source has a valid instr.
- instr_ready  out  1  sequencer can accept an instruction this cycle.
- instr  in  10  instruction fields:
  - [9:8] op
  - [7:6] rd
  - [5:4] rs1
  - [3:2] rs2
  - [1:0] reserved, ignored
  - LDI immediate is instr[5:2].
- rs1, rs2  out  ADDR_W  register file read selects.
- rd  out  ADDR_W  register file write select.
- RuWr  out  1  register file write enable.
- RuWrData  out  DATA_W  register file write data.
- ru1, ru2  in  DATA_W  register file read data, combinational from rs1/rs2.
- busy  out  1  high in READ and EXEC.
- done  out  1  one-cycle pulse in WB.
- flag_z  out  1  last result was zero.
- flag_c  out  1  carry of ADD / borrow of SUB; cleared by AND and LDI.

## Operation
- Opcodes:
  - 00 ADD: rd ← rs1 + rs2 (mod 16), flag_c = bit 4 of the 5-bit sum.
  - 01 SUB: rd ← rs1 − rs2 (mod 16), flag_c = 1 iff rs1 < rs2 (unsigned).
  - 10 AND: rd ← rs1 & rs2, flag_c = 0.
  - 11 LDI: rd ← imm4, flag_c = 0; no register read is needed, but READ still occurs.
- flag_z = (result == 0) for every op.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. instr_valid → capture instr into IR, go to READ.
  - READ: rs1/rs2 driven from IR. Latch ru1→A and ru2→B at the end of the cycle, go to EXEC.
  - EXEC: ALU computes from A, B, IR. Latch result→R and update flags, go to WB.
  - WB: RuWr=1, rd=IR.rd, RuWrData=R, done=1, instr_ready=1.
    - instr_valid → capture the new instr, go to READ (back-to-back).
    - Otherwise go to IDLE.
- A handshake occurs only when instr_valid && instr_ready. Instructions presented while instr_ready=0 are not consumed. The source holds instr stable until accepted.
- A back-to-back instruction reading the register just written in WB sees the new value: the write commits at the WB edge, and READ follows.
- rs1/rs2/rd are always driven from IR and are don't-care outside READ/WB. RuWr is high only in WB.
- Reset (any time, including mid-instruction):
  - state → IDLE.
  - IR, A, B, R, flag_z, flag_c → 0.
  - RuWr, done, busy → 0 immediately (asynchronously).
  - instr_ready → 1 after reset.
  - A write in progress is aborted (RuWr drops before the edge).
  - Register file contents are not reset.

## Timing
- Accept at edge N.
  - READ in cycle N+1, EXEC in N+2, WB in N+3.
  - Write commits at edge N+4.
- Latency from accept to commit: 4 edges. Throughput: one instruction per 3 cycles back-to-back, 4 with an idle gap.
- flag_z/flag_c update at the EXEC→WB edge and hold until the next EXEC.
- Outputs are registered or decoded from state only. There is no combinational path from instr_valid to any output except instr_ready, which is state-decoded only.

## Structure
- Shared package cpu_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_AND, OP_LDI).
  - state_e enum.
  - Instruction field position localparams.
  - DATA_W/ADDR_W defaults.
- Sub-module cpu_alu: combinational; inputs op, a, b, imm; outputs result, carry, zero.
- regfile_sequencer holds the FSM, IR, A/B/R registers and flags. The bench instantiates it together with the existing register file.

## Test plan
- Reset held, then released → instr_ready=1, RuWr=0, flags 0, busy=0. Then LDI r1,#5 (instr=11_01_0101_00) → RuWr=1, rd=1, RuWrData=5 in cycle N+3; flag_z=0.
- LDI r1,#9; LDI r2,#9; ADD r3,r1,r2 → r3=2, flag_c=1, flag_z=0. Then SUB r0,r1,r2 → r0=0, flag_z=1, flag_c=0.
- SUB with r1=3, r2=7 → result 12, flag_c=1. AND of 0xC and 0x3 → 0, flag_z=1, flag_c=0.
- instr_valid held high continuously with LDI r2,#6 then ADD r3,r2,r2 → second accept happens in WB, and r3 commits 12 exactly 3 cycles after r2's commit.
- instr_valid asserted during READ/EXEC → not accepted (instr_ready=0), then accepted in WB with no instruction lost or duplicated.
- rst asserted during WB of LDI r0,#15 → RuWr drops in the same cycle. r0 keeps its prior value. FSM returns to IDLE with flags 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file sequencer and its ALU.
// Contents: data/address width defaults, instruction field positions,
// the opcode and FSM state enumerations, and a state-decode helper.
package cpu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;
  localparam int INSTR_W    = 10;

  // Instruction field positions
  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 2;
  // LDI immediate overlays the rs1/rs2 fields
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LDI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  // A new instruction may be taken in IDLE, or in WB for back-to-back issue.
  function automatic logic state_accepts(input state_e s);
    return (s == ST_IDLE) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the sequencer.
// Ports:
//   op_i     : opcode (ADD/SUB/AND/LDI)
//   a_i, b_i : operands
//   imm_i    : LDI immediate
//   result_o : result, modulo 2^DATA_W
//   carry_o  : ADD carry-out / SUB borrow; 0 for AND and LDI
//   zero_o   : result is zero
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] ext_s;

  // One extra bit holds the ADD carry; for SUB it is the borrow (a < b).
  always_comb begin
    ext_s = '0;
    case (op_e'(op_i))
      OP_ADD:  ext_s = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  ext_s = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  ext_s = {1'b0, a_i & b_i};
      OP_LDI:  ext_s = {1'b0, imm_i};
      default: ext_s = '0;
    endcase
  end

  assign result_o = ext_s[DATA_W-1:0];
  assign carry_o  = ext_s[DATA_W];
  assign zero_o   = (ext_s[DATA_W-1:0] == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle initiator for a 4 x 4-bit register file: takes one
// instruction per valid/ready handshake and steps READ -> EXEC -> WB.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   instr_valid/ready     : instruction handshake (ready is state-decoded)
//   instr [9:0]           : {op, rd, rs1, rs2, reserved}
//   rs1, rs2              : register file read selects
//   ru1, ru2              : register file read data (combinational)
//   rd, RuWr, RuWrData    : register file write select/enable/data
//   busy, done            : in READ/EXEC; one-cycle pulse in WB
//   flag_z, flag_c        : zero and carry/borrow of the last result
module regfile_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [9:0]        instr,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  output logic [ADDR_W-1:0] rd,
  output logic              RuWr,
  output logic [DATA_W-1:0] RuWrData,
  input  logic [DATA_W-1:0] ru1,
  input  logic [DATA_W-1:0] ru2,
  output logic              busy,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [DATA_W-1:0]    a_q, b_q, r_q;
  logic                 flag_z_q, flag_c_q;
  logic [DATA_W-1:0]    alu_res_s;
  logic                 alu_carry_s, alu_zero_s;
  logic                 accept_s;
  logic                 unused_ir_s;

  // Reserved instruction bits are carried in IR but never decoded.
  assign unused_ir_s = ^ir_q[1:0];

  assign accept_s = instr_valid && state_accepts(state_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) state_d = ST_READ;
        else             state_d = ST_IDLE;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        if (instr_valid) state_d = ST_READ;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the state register only, so reset
  // clears RuWr/done/busy immediately and instr_valid never reaches them.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    RuWr        = 1'b0;
    case (state_q)
      ST_IDLE: instr_ready = 1'b1;
      ST_READ: busy = 1'b1;
      ST_EXEC: busy = 1'b1;
      ST_WB: begin
        instr_ready = 1'b1;
        done        = 1'b1;
        RuWr        = 1'b1;
      end
      default: instr_ready = 1'b0;
    endcase
  end

  // Datapath: IR on accept, operands at the end of READ, result and flags at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (accept_s) begin
        ir_q <= instr;
      end
      if (state_q == ST_READ) begin
        a_q <= ru1;
        b_q <= ru2;
      end
      if (state_q == ST_EXEC) begin
        r_q      <= alu_res_s;
        flag_z_q <= alu_zero_s;
        flag_c_q <= alu_carry_s;
      end
    end
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (ir_q[OP_MSB:OP_LSB]),
    .a_i      (a_q),
    .b_i      (b_q),
    .imm_i    (ir_q[IMM_MSB:IMM_LSB]),
    .result_o (alu_res_s),
    .carry_o  (alu_carry_s),
    .zero_o   (alu_zero_s)
  );

  assign rs1      = ir_q[RS1_MSB:RS1_LSB];
  assign rs2      = ir_q[RS2_MSB:RS2_LSB];
  assign rd       = ir_q[RD_MSB:RD_LSB];
  assign RuWrData = r_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer with a behavioural register file
// and a reference model of the instruction set.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [1:0] rs1, rs2, rd;
  logic       RuWr;
  logic [3:0] RuWrData;
  logic [3:0] ru1, ru2;
  logic       busy, done, flag_z, flag_c;

  int tests = 0;
  int fails = 0;

  logic [3:0] rf  [4];   // register file attached to the DUT
  logic [3:0] mrf [4];   // reference model's register contents

  regfile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .RuWr        (RuWr),
    .RuWrData    (RuWrData),
    .ru1         (ru1),
    .ru2         (ru2),
    .busy        (busy),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  always #5 clk = ~clk;

  assign ru1 = rf[rs1];
  assign ru2 = rf[rs2];

  always @(posedge clk) begin
    if (RuWr) rf[rd] <= RuWrData;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {zero, carry, result[3:0]} computed with plain integer arithmetic.
  function automatic logic [5:0] ref_exec(input logic [9:0] ins, input logic [3:0] a, input logic [3:0] b);
    int av, bv, s;
    logic [3:0] res;
    logic c;
    av = a;
    bv = b;
    case (ins[9:8])
      2'd0: begin s = av + bv; res = 4'(s % 16); c = (s > 15); end
      2'd1: begin s = av - bv; res = 4'((s + 16) % 16); c = (s < 0); end
      2'd2: begin res = a & b; c = 1'b0; end
      default: begin res = ins[5:2]; c = 1'b0; end
    endcase
    return {(res == 4'd0), c, res};
  endfunction

  function automatic logic [9:0] mk(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2);
    return {op, d, s1, s2, 2'b00};
  endfunction

  function automatic logic [9:0] ldi(input logic [1:0] d, input logic [3:0] imm);
    return {2'b11, d, imm, 2'b00};
  endfunction

  // Runs one instruction from IDLE (acc=0) or from READ after a WB accept (acc=1).
  // With chain=1 the next instruction is presented from READ onward.
  // Entry and exit are 1 time unit after a rising edge.
  task automatic do_instr(input logic [9:0] ins, input bit acc, input bit chain, input logic [9:0] nxt);
    logic [5:0] e;
    if (!acc) begin
      instr       = ins;
      instr_valid = 1'b1;
      chk("idle_ready", instr_ready, 1);
      @(posedge clk); #1;
    end
    instr_valid = chain;
    instr       = chain ? nxt : ins;
    chk("read_busy", busy, 1);
    chk("read_ready", instr_ready, 0);
    chk("read_ruwr", RuWr, 0);
    chk("read_rs1", rs1, ins[5:4]);
    chk("read_rs2", rs2, ins[3:2]);
    e = ref_exec(ins, mrf[ins[5:4]], mrf[ins[3:2]]);
    @(posedge clk); #1;
    chk("exec_busy", busy, 1);
    chk("exec_ready", instr_ready, 0);
    chk("exec_done", done, 0);
    @(posedge clk); #1;
    chk("wb_ruwr", RuWr, 1);
    chk("wb_done", done, 1);
    chk("wb_busy", busy, 0);
    chk("wb_ready", instr_ready, 1);
    chk("wb_rd", rd, ins[7:6]);
    chk("wb_data", RuWrData, e[3:0]);
    chk("wb_flag_c", flag_c, e[4]);
    chk("wb_flag_z", flag_z, e[5]);
    @(posedge clk); #1;
    chk("commit", rf[ins[7:6]], e[3:0]);
    mrf[ins[7:6]] = e[3:0];
    if (chain) begin
      chk("chain_read", busy, 1);
    end else begin
      chk("post_idle_busy", busy, 0);
      chk("post_idle_ready", instr_ready, 1);
      chk("post_idle_ruwr", RuWr, 0);
    end
  endtask

  initial begin
    logic [9:0] cur, nxt;
    bit acc, ch;

    // Reset held, then released
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_ruwr", RuWr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", instr_ready, 1);

    // LDI r1,#5 ; the plan's literal encoding
    do_instr(10'b11_01_0101_00, 1'b0, 1'b0, 10'd0);
    chk("ldi_r1_5", rf[1], 4'd5);

    // ADD with carry, then SUB to zero
    do_instr(ldi(2'd1, 4'd9), 1'b0, 1'b0, 10'd0);
    do_instr(ldi(2'd2, 4'd9), 1'b0, 1'b0, 10'd0);
    do_instr(mk(2'b00, 2'd3, 2'd1, 2'd2), 1'b0, 1'b0, 10'd0);
    chk("add_r3", rf[3], 4'd2);
    chk("add_c", flag_c, 1);
    do_instr(mk(2'b01, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 10'd0);
    chk("sub_r0", rf[0], 4'd0);
    chk("sub_z", flag_z, 1);
    chk("sub_c", flag_c, 0);

    // SUB with borrow, AND to zero
    do_instr(ldi(2'd1, 4'd3), 1'b0, 1'b0, 10'd0);
    do_instr(ldi(2'd2, 4'd7), 1'b0, 1'b0, 10'd0);
    do_instr(mk(2'b01, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 10'd0);
    chk("sub_borrow_r0", rf[0], 4'd12);
    chk("sub_borrow_c", flag_c, 1);
    do_instr(ldi(2'd1, 4'hC), 1'b0, 1'b0, 10'd0);
    do_instr(ldi(2'd2, 4'h3), 1'b0, 1'b0, 10'd0);
    do_instr(mk(2'b10, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 10'd0);
    chk("and_r0", rf[0], 4'd0);
    chk("and_z", flag_z, 1);
    chk("and_c", flag_c, 0);

    // Back-to-back with instr_valid held high; the ADD reads r2 just written
    do_instr(ldi(2'd2, 4'd6), 1'b0, 1'b1, mk(2'b00, 2'd3, 2'd2, 2'd2));
    do_instr(mk(2'b00, 2'd3, 2'd2, 2'd2), 1'b1, 1'b0, 10'd0);
    chk("b2b_r3", rf[3], 4'd12);

    // Randomized instructions, randomly chained or separated by idle gaps
    cur = 10'($urandom);
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt = 10'($urandom);
      ch  = (i < 39) && ($urandom_range(0, 1) == 1);
      do_instr(cur, acc, ch, nxt);
      cur = nxt;
      acc = ch;
      if (!ch) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          chk("gap_idle_busy", busy, 0);
        end
      end
    end

    // Reset during WB of LDI r0,#15 aborts the write
    instr       = ldi(2'd0, 4'd15);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_wb_ruwr", RuWr, 1);
    rst = 1'b1;
    #1;
    chk("abort_ruwr", RuWr, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_flag_z", flag_z, 0);
    chk("abort_flag_c", flag_c, 0);
    chk("abort_data", RuWrData, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_r0_kept", rf[0], mrf[0]);
    @(posedge clk); #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ready", instr_ready, 1);

    // Recovery after the aborted instruction
    do_instr(ldi(2'd0, 4'd15), 1'b0, 1'b0, 10'd0);
    chk("recover_r0", rf[0], 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
